// File: rtl/oled_pixel_streamer.sv
// Raster-scanning OLED pixel transmitter: walks x/y, captures the registered
// RGB565 colour returned by the pixel source and shifts it out MSB-first.
module oled_pixel_streamer #(
  parameter int WIDTH   = 96,
  parameter int HEIGHT  = 64,
  parameter int CLK_DIV = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        en,
  input  logic [15:0] pixel_in,
  output logic [9:0]  x,
  output logic [6:0]  y,
  output logic        cs_n,
  output logic        sclk,
  output logic        mosi,
  output logic        frame_start,
  output logic        frame_done,
  output logic        busy
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [9:0]    X_LAST   = 10'(WIDTH - 1);
  localparam logic [6:0]    Y_LAST   = 7'(HEIGHT - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, SHIFT, DONE} state_e;

  state_e        state_q;
  logic [15:0]   sr_q;
  logic [3:0]    bit_q;
  logic [DW-1:0] div_q;
  logic [9:0]    x_q, x_d;
  logic [6:0]    y_q, y_d;
  logic          cs_n_q, sclk_q, fs_q, fd_q, busy_q;
  logic          last_pix, phase_end;

  assign last_pix  = (x_q == X_LAST) && (y_q == Y_LAST);
  assign phase_end = (div_q == DIV_LAST);

  always_comb begin
    x_d = x_q + 10'd1;
    y_d = y_q;
    if (x_q == X_LAST) begin
      x_d = '0;
      y_d = y_q + 7'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      sr_q    <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      fs_q    <= 1'b0;
      fd_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            state_q <= ADDR;
            cs_n_q  <= 1'b0;
            fs_q    <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ADDR: begin
          fs_q    <= 1'b0;
          state_q <= WAIT;
        end
        WAIT: begin
          // Source is registered: colour for this x/y is valid on this edge.
          sr_q    <= pixel_in;
          bit_q   <= '0;
          div_q   <= '0;
          sclk_q  <= 1'b0;
          state_q <= SHIFT;
        end
        SHIFT: begin
          if (!phase_end) begin
            div_q <= div_q + 1'b1;
          end else begin
            div_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              // End of high phase: bit boundary, mosi may move now.
              sclk_q <= 1'b0;
              sr_q   <= {sr_q[14:0], 1'b0};
              bit_q  <= bit_q + 4'd1;
              if (bit_q == 4'd15) begin
                if (last_pix) begin
                  state_q <= DONE;
                  cs_n_q  <= 1'b1;
                  fd_q    <= 1'b1;
                  x_q     <= '0;
                  y_q     <= '0;
                end else begin
                  state_q <= ADDR;
                  x_q     <= x_d;
                  y_q     <= y_d;
                end
              end
            end
          end
        end
        DONE: begin
          fd_q    <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // After 16 shifts the register is empty, so mosi idles low by construction.
  assign mosi        = sr_q[15];
  assign x           = x_q;
  assign y           = y_q;
  assign cs_n        = cs_n_q;
  assign sclk        = sclk_q;
  assign frame_start = fs_q;
  assign frame_done  = fd_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_oled_pixel_streamer.sv
// Scoreboard bench for oled_pixel_streamer: expected pixels are queued per
// frame and a negedge monitor reassembles each 16-bit word from sclk rises.
module tb_oled_pixel_streamer;
  localparam int W = 5;
  localparam int H = 3;
  localparam int D = 2;
  localparam int P = 2 + 32 * D;
  localparam int N = W * H;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        en = 1'b0;
  logic [15:0] pixel_in = 16'h0;
  logic [9:0]  x;
  logic [6:0]  y;
  logic        cs_n, sclk, mosi, frame_start, frame_done, busy;

  oled_pixel_streamer #(.WIDTH(W), .HEIGHT(H), .CLK_DIV(D)) dut (
    .CLK(CLK), .RST_N(RST_N), .en(en), .pixel_in(pixel_in),
    .x(x), .y(y), .cs_n(cs_n), .sclk(sclk), .mosi(mosi),
    .frame_start(frame_start), .frame_done(frame_done), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [9:0]  x;
    logic [6:0]  y;
    logic [15:0] c;
  } pix_t;

  pix_t        sb[$];
  pix_t        e_m;
  logic [15:0] colour [H][W];
  int checks = 0, passes = 0, cyc = 0;
  int fs_count = 0, fd_count = 0, fs_cyc = 0, fs_prev = 0, last_pix = 0, bitn = 0;
  logic [15:0] word = 16'h0;
  logic        sclk_p = 1'b0, mosi_p = 1'b0, fs_p = 1'b0;
  logic [9:0]  x_p = '0;
  logic [6:0]  y_p = '0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Registered pixel source: one cycle of latency from x/y to colour.
  always @(posedge CLK)
    pixel_in <= (int'(x) < W && int'(y) < H) ? colour[int'(y)][int'(x)] : 16'h0;

  always @(negedge CLK) begin
    if (!RST_N) begin
      bitn = 0; sclk_p = 1'b0; mosi_p = 1'b0; fs_p = 1'b0;
    end else begin
      if (sclk && !sclk_p) begin
        check("cs_low_on_sclk", cs_n, 0);
        word = {word[14:0], mosi};
        bitn++;
        if (bitn == 16) begin
          bitn = 0;
          if (sb.size() == 0) begin
            checks++;
            $display("FAIL unexpected_pixel: got %h at (%0d,%0d), expected none", word, x, y);
          end else begin
            e_m = sb.pop_front();
            check("pixel_colour", word, e_m.c);
            check("pixel_x", x, e_m.x);
            check("pixel_y", y, e_m.y);
          end
        end
      end
      if (sclk && sclk_p) check("mosi_stable_high", mosi, mosi_p);
      if (frame_start) begin
        check("frame_start_width", fs_p, 0);
        check("frame_start_xy", {x, y}, 0);
        fs_prev = fs_cyc; fs_cyc = cyc; last_pix = cyc; fs_count++;
      end else if (!cs_n && (x != x_p || y != y_p)) begin
        check("pixel_period", cyc - last_pix, P);
        last_pix = cyc;
      end
      if (frame_done) begin
        fd_count++;
        check("done_cs_n", cs_n, 1);
        check("frame_len", cyc - fs_cyc, N * P);
      end
      sclk_p = sclk; mosi_p = mosi; fs_p = frame_start;
    end
    x_p = x; y_p = y;
  end

  task automatic fill(input int mode);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (mode)
          1:       colour[r][c] = (c < 2) ? 16'hFFFF : 16'h0000;
          default: colour[r][c] = 16'($urandom);
        endcase
    if (mode == 2) colour[0][0] = 16'hA5C3;
  endtask

  task automatic push_frame();
    pix_t e;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        e.x = 10'(c); e.y = 7'(r); e.c = colour[r][c];
        sb.push_back(e);
      end
  endtask

  task automatic pulse_en();
    @(posedge CLK); #1 en = 1'b1;
    @(posedge CLK); #1 en = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (fd_count < target && n < budget) begin @(posedge CLK); n++; end
    check("frame_done_seen", fd_count, target);
    repeat (5) @(posedge CLK);
    check("scoreboard_drained", sb.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_x"}, x, 0);
    check({tag, "_y"}, y, 0);
    check({tag, "_cs_n"}, cs_n, 1);
    check({tag, "_sclk"}, sclk, 0);
    check({tag, "_mosi"}, mosi, 0);
    check({tag, "_frame_start"}, frame_start, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int n, f, bz, fd0;
    fill(0);
    repeat (3) @(posedge CLK);
    #1 check_reset_outputs("reset");
    RST_N = 1'b1;

    // Single pixel pattern with known first word, then column pattern.
    fill(2); push_frame(); pulse_en(); wait_done(1, N * P + 50);
    fill(1); push_frame(); pulse_en(); wait_done(2, N * P + 50);
    for (int i = 0; i < 2; i++) begin
      fill(0); push_frame(); pulse_en(); wait_done(3 + i, N * P + 50);
    end

    // Asynchronous reset in the high phase of bit 7 of the first pixel.
    fill(0); f = fs_count; fd0 = fd_count;
    pulse_en();
    @(posedge CLK); @(posedge CLK);
    repeat (7 * 2 * D + D) @(posedge CLK);
    #2;
    check("pre_reset_sclk", sclk, 1);
    check("pre_reset_bits_seen", bitn, 7);
    check("pre_reset_frame_started", fs_count, f + 1);
    RST_N = 1'b0;
    #1 check_reset_outputs("async_reset");
    sb.delete();
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    bz = 0;
    repeat (100) begin @(negedge CLK); if (busy) bz++; end
    check("idle_busy_after_reset", bz, 0);
    check("no_done_after_reset", fd_count, fd0);

    // en dropped mid-frame: frame completes, no restart.
    fill(0); push_frame();
    @(posedge CLK); #1 en = 1'b1;
    n = 0;
    while (!(x == 10'd2 && y == 7'd1) && n < N * P + 50) begin @(posedge CLK); n++; end
    check("reached_pixel_2_1", {x, y}, {10'd2, 7'd1});
    #1 en = 1'b0;
    wait_done(fd0 + 1, N * P + 50);
    f = fs_count;
    repeat (1000) @(posedge CLK);
    check("no_restart_after_en_drop", fs_count, f);

    // en held high across two frames: 2-cycle gap between them.
    fill(0); push_frame(); push_frame();
    f = fs_count;
    @(posedge CLK); #1 en = 1'b1;
    n = 0;
    while (fs_count < f + 2 && n < 2 * N * P + 50) begin @(posedge CLK); n++; end
    #1 en = 1'b0;
    check("back_to_back_starts", fs_count, f + 2);
    check("frame_start_spacing", fs_cyc - fs_prev, N * P + 2);
    wait_done(fd0 + 3, N * P + 50);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
